mem_access_stage: RTL

- Memory stage of the SPARC pipeline. Sits directly after the Execute stage.
- Consumes the Execute stage's ALU result, store data, opcode fields and register-write controls. Returns the `mem_ready` backpressure signal that Execute uses to stall.
- Performs loads and stores over a 64-bit data-cache request/ack port, including byte/half extraction and store byte-lane steering.
- Delivers a registered result to the writeback stage.

---
 rtl/mem_access_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: SPARC memory stage. Loads/stores over a 64-bit dcache req/ack port; registered WB result. Build option: MEM_ALIGN_CHECK_EN.
// Latency: non-memory op 1 cycle; memory op 2+N cycles (N = REQ cycles before dc_ack).
// Backpressure: mem_ready drops while a cache access is outstanding; Execute holds its inputs stable meanwhile.
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] MEM_alures_in,
  input  logic [DATA_W-1:0] MEM_valD_in,
  input  logic [1:0]        MEM_op_in,
  input  logic [2:0]        MEM_op2_in,
  input  logic [5:0]        MEM_op3_in,
  input  logic [4:0]        MEM_regD_in,
  input  logic              MEM_regWrite_in,
  input  logic              MEM_regWriteDouble_in,
  output logic              mem_ready,
  output logic              dc_req,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [DATA_W-1:0] dc_wdata,
  output logic [7:0]        dc_bmask,
  input  logic              dc_ack,
  input  logic [DATA_W-1:0] dc_rdata,
  output logic              WB_valid,
  output logic [4:0]        WB_regD,
  output logic [DATA_W-1:0] WB_data,
  output logic              WB_regWrite,
  output logic              WB_regWriteDouble,
  output logic              WB_trap
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;

  // Access size encoding: 0 byte, 1 half, 2 word, 3 doubleword
  logic       d_mem, d_load, d_signed;
  logic [1:0] d_size;
  logic [2:0] d_mask, d_off;
  logic       d_trap, d_bubble;
  logic [DATA_W-1:0] st_wdata;
  logic [7:0]        st_bmask;

  // Parameters of the access in flight, captured at acceptance
  logic [4:0] p_regD;
  logic       p_regWrite, p_load, p_signed;
  logic [1:0] p_size;
  logic [2:0] p_off;
  logic [DATA_W-1:0] rd_sh, ld_res;

  assign d_bubble = (MEM_op_in == 2'b00) && (MEM_op2_in == 3'b100) && (MEM_regD_in == 5'd0);

  // Decode op3 of a memory-format instruction into kind, size and signedness
  always_comb begin
    d_mem    = 1'b0;
    d_load   = 1'b0;
    d_signed = 1'b0;
    d_size   = 2'd2;
    if (MEM_op_in == 2'b11) begin
      case (MEM_op3_in)
        6'b000000: begin d_mem = 1'b1; d_load = 1'b1; d_size = 2'd2; end
        6'b000001: begin d_mem = 1'b1; d_load = 1'b1; d_size = 2'd0; end
        6'b000010: begin d_mem = 1'b1; d_load = 1'b1; d_size = 2'd1; end
        6'b000011: begin d_mem = 1'b1; d_load = 1'b1; d_size = 2'd3; end
        6'b001001: begin d_mem = 1'b1; d_load = 1'b1; d_signed = 1'b1; d_size = 2'd0; end
        6'b001010: begin d_mem = 1'b1; d_load = 1'b1; d_signed = 1'b1; d_size = 2'd1; end
        6'b000100: begin d_mem = 1'b1; d_size = 2'd2; end
        6'b000101: begin d_mem = 1'b1; d_size = 2'd0; end
        6'b000110: begin d_mem = 1'b1; d_size = 2'd1; end
        6'b000111: begin d_mem = 1'b1; d_size = 2'd3; end
        default:   d_mem = 1'b0;
      endcase
    end
  end

  // Keep only the offset bits meaningful for the access size (natural alignment)
  always_comb begin
    case (d_size)
      2'd0:    d_mask = 3'b111;
      2'd1:    d_mask = 3'b110;
      2'd2:    d_mask = 3'b100;
      default: d_mask = 3'b000;
    endcase
  end
  assign d_off = MEM_alures_in[2:0] & d_mask;

`ifdef MEM_ALIGN_CHECK_EN
  assign d_trap = d_mem && ((MEM_alures_in[2:0] & ~d_mask) != 3'b000);
`else
  // Misaligned low bits are simply dropped by d_off; no trap is ever raised
  assign d_trap = 1'b0;
`endif

  // Store lane steering: replicate the datum across the doubleword, enable only its bytes
  always_comb begin
    case (d_size)
      2'd0:    begin st_wdata = {8{MEM_valD_in[7:0]}};  st_bmask = 8'h80 >> d_off; end
      2'd1:    begin st_wdata = {4{MEM_valD_in[15:0]}}; st_bmask = 8'hC0 >> d_off; end
      2'd2:    begin st_wdata = {2{MEM_valD_in[31:0]}}; st_bmask = 8'hF0 >> d_off; end
      default: begin st_wdata = MEM_valD_in;            st_bmask = 8'hFF;          end
    endcase
  end

  // Load extraction: shift the addressed byte lane to the top, then take the datum's width
  assign rd_sh = dc_rdata << {p_off, 3'b000};
  always_comb begin
    case (p_size)
      2'd0:    ld_res = {32'd0, {24{p_signed & rd_sh[63]}}, rd_sh[63:56]};
      2'd1:    ld_res = {32'd0, {16{p_signed & rd_sh[63]}}, rd_sh[63:48]};
      2'd2:    ld_res = {32'd0, rd_sh[63:32]};
      default: ld_res = dc_rdata;
    endcase
  end

  // Stage FSM: accept in IDLE/DONE, hold in REQ until dc_ack, all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      mem_ready         <= 1'b1;
      dc_req            <= 1'b0;
      dc_we             <= 1'b0;
      dc_addr           <= '0;
      dc_wdata          <= '0;
      dc_bmask          <= 8'h00;
      WB_valid          <= 1'b0;
      WB_regD           <= 5'd0;
      WB_data           <= '0;
      WB_regWrite       <= 1'b0;
      WB_regWriteDouble <= 1'b0;
      WB_trap           <= 1'b0;
      p_regD            <= 5'd0;
      p_regWrite        <= 1'b0;
      p_load            <= 1'b0;
      p_signed          <= 1'b0;
      p_size            <= 2'd0;
      p_off             <= 3'd0;
    end else begin
      case (state)
        REQ: begin
          if (dc_ack) begin
            state             <= DONE;
            mem_ready         <= 1'b1;
            dc_req            <= 1'b0;
            WB_valid          <= 1'b1;
            WB_regD           <= p_regD;
            WB_trap           <= 1'b0;
            WB_data           <= p_load ? ld_res : '0;
            WB_regWrite       <= p_load & p_regWrite;
            WB_regWriteDouble <= p_load & (p_size == 2'd3);
          end
        end
        default: begin
          WB_regD <= MEM_regD_in;
          WB_trap <= d_trap;
          if (d_mem && !d_trap) begin
            state             <= REQ;
            mem_ready         <= 1'b0;
            dc_req            <= 1'b1;
            dc_we             <= ~d_load;
            dc_addr           <= {MEM_alures_in[ADDR_W-1:3], 3'b000};
            dc_wdata          <= d_load ? '0 : st_wdata;
            dc_bmask          <= st_bmask;
            WB_valid          <= 1'b0;
            WB_data           <= '0;
            WB_regWrite       <= 1'b0;
            WB_regWriteDouble <= 1'b0;
            p_regD            <= MEM_regD_in;
            p_regWrite        <= MEM_regWrite_in;
            p_load            <= d_load;
            p_signed          <= d_signed;
            p_size            <= d_size;
            p_off             <= d_off;
          end else if (d_trap) begin
            state             <= IDLE;
            WB_valid          <= 1'b1;
            WB_data           <= '0;
            WB_regWrite       <= 1'b0;
            WB_regWriteDouble <= 1'b0;
          end else begin
            // Non-memory (including unknown op3 under op=11, which must not write)
            state             <= IDLE;
            WB_valid          <= ~d_bubble;
            WB_data           <= {32'd0, MEM_alures_in};
            WB_regWrite       <= MEM_regWrite_in & (MEM_op_in != 2'b11) & ~d_bubble;
            WB_regWriteDouble <= MEM_regWriteDouble_in & ~d_bubble;
          end
        end
      endcase
    end
  end

endmodule
